// File: rtl/req_pending_latch_if.sv
// req_pending_latch_if
//   Bundles the request/acknowledge/debug signals of req_pending_latch.
//   master : request sources, ack/err_clr driver (drives req_in, mask, ack,
//            ack_idx, err_clr; observes pend_out, pend_valid, ack_err, ovf_cnt)
//   slave  : the pending latch itself
interface req_pending_latch_if;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic       err_clr;
  logic [7:0] pend_out;
  logic       pend_valid;
  logic       ack_err;
  logic [7:0] ovf_cnt;

  modport master (
    output req_in, mask, ack, ack_idx, err_clr,
    input  pend_out, pend_valid, ack_err, ovf_cnt
  );

  modport slave (
    input  req_in, mask, ack, ack_idx, err_clr,
    output pend_out, pend_valid, ack_err, ovf_cnt
  );
endinterface

// File: rtl/req_pending_latch.sv
// req_pending_latch
//   Captures eight request lines into a pending register feeding an 8-to-3
//   priority encoder; clears the serviced bit on ack, counts lost requests
//   and flags acks of non-pending bits.
// Parameters:
//   EDGE : 1 = rising-edge capture, 0 = level capture
// Optional build macro:
//   REQ_SYNC_EN : 2-flop synchronizer on every req_in bit (adds 2 cycles)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): req_in, mask, ack, ack_idx, err_clr in;
//                pend_out, pend_valid, ack_err, ovf_cnt out
module req_pending_latch #(
  parameter bit EDGE = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  req_pending_latch_if.slave  bus
);

  logic [7:0] req_s;
  logic [7:0] req_q,  req_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] ovf_q,  ovf_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] set_bits;
  logic [7:0] clr_bits;
  logic [7:0] lost_bits;

`ifdef REQ_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.req_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = bus.req_in;
`endif

  always_comb begin
    req_d    = req_s;
    set_bits = EDGE ? (req_s & ~req_q) : req_s;

    clr_bits = '0;
    if (bus.ack) clr_bits[bus.ack_idx] = 1'b1;

    // Set is applied after clear so a same-cycle collision leaves the bit set.
    pend_d = (pend_q & ~clr_bits) | set_bits;

    // A request is lost only when it lands on a bit that stays pending.
    lost_bits = EDGE ? (set_bits & pend_q & ~clr_bits) : '0;

    ovf_d = ovf_q;
    if ((|lost_bits) && (ovf_q != '1)) ovf_d = ovf_q + 8'd1;

    ack_err_d = ack_err_q & ~bus.err_clr;
    if (bus.ack && !pend_q[bus.ack_idx]) ack_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.pend_out   = pend_q & bus.mask;
  assign bus.pend_valid = |bus.pend_out;
  assign bus.ack_err    = ack_err_q;
  assign bus.ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_req_pending_latch.sv
module tb_req_pending_latch;

`ifdef REQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  req_pending_latch_if bus  ();
  req_pending_latch_if bus2 ();

  req_pending_latch #(.EDGE(1'b1)) dut_edge (.clk(clk), .rst_n(rst_n), .bus(bus));
  req_pending_latch #(.EDGE(1'b0)) dut_lvl  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the edge-mode block: per-bit pending flags, an
  // integer overflow counter and a history of raw request samples.
  logic [7:0] m_pend, m_prev, m_h0, m_h1;
  int         m_ovf;
  bit         m_err;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_h0 = '0; m_h1 = '0; m_ovf = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s, nxt;
    bit any_lost, set_i, clr_i, nerr;
    s = (LAT == 0) ? bus.req_in : m_h1;
    nxt = m_pend;
    any_lost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_i = s[i] && !m_prev[i];
      clr_i = bus.ack && (int'(bus.ack_idx) == i);
      if (set_i && m_pend[i] && !clr_i) any_lost = 1'b1;
      if (set_i)      nxt[i] = 1'b1;
      else if (clr_i) nxt[i] = 1'b0;
    end
    if (bus.ack && !m_pend[bus.ack_idx]) nerr = 1'b1;
    else if (bus.err_clr)                nerr = 1'b0;
    else                                 nerr = m_err;
    if (any_lost && m_ovf < 255) m_ovf = m_ovf + 1;
    m_err  = nerr;
    m_pend = nxt;
    m_prev = s;
    m_h1   = m_h0;
    m_h0   = bus.req_in;
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] idx;
    logic       err_clr;
    logic [7:0] exp_pend;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_ovf;
  } vec_t;

  vec_t vecs[18];

  initial begin
    checks = 0;
    failures = 0;

    vecs[0]  = '{8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{8'h00, 8'hFF, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{8'h81, 8'h7F, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h81, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{8'h00, 8'hFF, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{8'h04, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{8'h04, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{8'h00, 8'hFF, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{8'h20, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 8'd1};
    vecs[11] = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b0, 8'd1};
    vecs[12] = '{8'h20, 8'hFF, 1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 1'b0, 8'd1};
    vecs[13] = '{8'h00, 8'hFF, 1'b1, 3'd4, 1'b0, 8'h20, 1'b1, 1'b1, 8'd1};
    vecs[14] = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b0, 8'd1};
    vecs[15] = '{8'h00, 8'hFF, 1'b1, 3'd4, 1'b1, 8'h20, 1'b1, 1'b1, 8'd1};
    vecs[16] = '{8'h00, 8'hFF, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
    vecs[17] = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd1};

    rst_n = 1'b0;
    bus.req_in = '0;  bus.mask = 8'hFF;  bus.ack = 1'b0;  bus.ack_idx = '0;  bus.err_clr = 1'b0;
    bus2.req_in = '0; bus2.mask = 8'hFF; bus2.ack = 1'b0; bus2.ack_idx = '0; bus2.err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pend_out",   bus.pend_out,   8'h00);
    chk("reset_pend_valid", bus.pend_valid, 1'b0);
    chk("reset_ack_err",    bus.ack_err,    1'b0);
    chk("reset_ovf_cnt",    bus.ovf_cnt,    8'd0);
    rst_n = 1'b1;

    // Each row's inputs are held for LAT extra edges (ack/err_clr only once)
    // so the same expectations hold with or without the synchronizer.
    for (int r = 0; r < 18; r++) begin
      bus.req_in  = vecs[r].req;
      bus.mask    = vecs[r].mask;
      bus.ack     = vecs[r].ack;
      bus.ack_idx = vecs[r].idx;
      bus.err_clr = vecs[r].err_clr;
      tick();
      bus.ack = 1'b0;
      bus.err_clr = 1'b0;
      repeat (LAT) tick();
      chk($sformatf("vec%0d_pend_out", r),   bus.pend_out,   vecs[r].exp_pend);
      chk($sformatf("vec%0d_pend_valid", r), bus.pend_valid, vecs[r].exp_valid);
      chk($sformatf("vec%0d_ack_err", r),    bus.ack_err,    vecs[r].exp_err);
      chk($sformatf("vec%0d_ovf_cnt", r),    bus.ovf_cnt,    vecs[r].exp_ovf);
    end

    // Saturation: first pulse pends bit 2, the other 299 are all lost.
    for (int n = 0; n < 300; n++) begin
      bus.req_in = 8'h04;
      repeat (1 + LAT) tick();
      bus.req_in = 8'h00;
      repeat (1 + LAT) tick();
    end
    chk("sat_ovf_cnt",  bus.ovf_cnt,  8'd255);
    chk("sat_pend_out", bus.pend_out, 8'h04);

    // Level mode: a held line re-pends through its own ack.
    bus2.req_in = 8'h10;
    repeat (1 + LAT) tick();
    chk("lvl_pend_out",   bus2.pend_out,   8'h10);
    chk("lvl_pend_valid", bus2.pend_valid, 1'b1);
    bus2.ack = 1'b1;
    bus2.ack_idx = 3'd4;
    tick();
    bus2.ack = 1'b0;
    chk("lvl_after_ack_pend", bus2.pend_out, 8'h10);
    chk("lvl_ack_err",        bus2.ack_err,  1'b0);
    tick();
    chk("lvl_ovf_cnt",        bus2.ovf_cnt,  8'd0);

    // Asynchronous reset mid-run, away from any clock edge.
    bus.req_in = 8'h08;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pend_out",   bus.pend_out,    8'h00);
    chk("arst_pend_valid", bus.pend_valid,  1'b0);
    chk("arst_ack_err",    bus.ack_err,     1'b0);
    chk("arst_ovf_cnt",    bus.ovf_cnt,     8'd0);
    chk("arst_lvl_pend",   bus2.pend_out,   8'h00);
    chk("arst_lvl_valid",  bus2.pend_valid, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // A line high across reset release is seen as a fresh edge.
    repeat (1 + LAT) tick();
    chk("release_edge_pend", bus.pend_out, 8'h08);
    chk("release_lvl_pend",  bus2.pend_out, 8'h10);
    bus2.req_in = 8'h00;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      bus.req_in  = bus.req_in ^ (8'($urandom) & 8'($urandom));
      bus.mask    = ($urandom_range(9, 0) == 0) ? 8'($urandom) : bus.mask;
      bus.ack     = ($urandom_range(2, 0) == 0);
      bus.ack_idx = 3'($urandom_range(7, 0));
      bus.err_clr = ($urandom_range(6, 0) == 0);
      tick();
      chk("rnd_pend_out",   bus.pend_out,   m_pend & bus.mask);
      chk("rnd_pend_valid", bus.pend_valid, |(m_pend & bus.mask));
      chk("rnd_ack_err",    bus.ack_err,    m_err);
      chk("rnd_ovf_cnt",    bus.ovf_cnt,    m_ovf[7:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
